// File: rtl/operand_fetch_if.sv
// Bundle of every handshake and bus signal around the operand fetch stage:
// decode input, execute output, writeback request and register file ports.
//
// Handshake rule for both in_* and out_*: a transfer happens on a rising edge
// where valid && ready are both 1. The producer keeps its payload stable while
// valid is high and ready is low; valid never depends on ready.
interface operand_fetch_if #(
   parameter int BITS = 32,
   parameter int ADDR = 5
);
   // decode -> stage
   logic            in_valid;
   logic            in_ready;
   logic [ADDR-1:0] in_rs1;
   logic [ADDR-1:0] in_rs2;
   logic [ADDR-1:0] in_rd;
   logic            in_wen;

   // stage -> execute
   logic            out_valid;
   logic            out_ready;
   logic [BITS-1:0] out_op_a;
   logic [BITS-1:0] out_op_b;
   logic [ADDR-1:0] out_rd;
   logic            out_wen;

   // writeback -> stage
   logic            wb_valid;
   logic [ADDR-1:0] wb_rd;
   logic [BITS-1:0] wb_data;

   // stage <-> register file
   logic [ADDR-1:0] rf_address_a;
   logic [ADDR-1:0] rf_address_b;
   logic [BITS-1:0] rf_data_a;
   logic [BITS-1:0] rf_data_b;
   logic [ADDR-1:0] rf_address_write;
   logic            rf_write_enable;
   logic [BITS-1:0] rf_data_write;

   // The operand fetch stage itself
   modport master (
      input  in_valid, in_rs1, in_rs2, in_rd, in_wen,
      input  out_ready,
      input  wb_valid, wb_rd, wb_data,
      input  rf_data_a, rf_data_b,
      output in_ready,
      output out_valid, out_op_a, out_op_b, out_rd, out_wen,
      output rf_address_a, rf_address_b,
      output rf_address_write, rf_write_enable, rf_data_write
   );

   // Everything around the stage (decode, execute, writeback, register file)
   modport slave (
      output in_valid, in_rs1, in_rs2, in_rd, in_wen,
      output out_ready,
      output wb_valid, wb_rd, wb_data,
      output rf_data_a, rf_data_b,
      input  in_ready,
      input  out_valid, out_op_a, out_op_b, out_rd, out_wen,
      input  rf_address_a, rf_address_b,
      input  rf_address_write, rf_write_enable, rf_data_write
   );
endinterface

// File: rtl/operand_fetch.sv
// Register-read stage between decode and execute. Reads two operands from the
// combinational register file, forces x0 to zero, bypasses a same-cycle
// writeback, tracks outstanding destination writes in a pending-bit
// scoreboard (stalling on RAW/WAW), and holds the operand bundle in a
// one-entry output register.
module operand_fetch #(
   parameter int BITS = 32,
   parameter int ADDR = 5
) (
   input logic              clk,
   input logic              rst_n,
   operand_fetch_if.master  bus
);
   localparam int NREG = 1 << ADDR;

   // output register and scoreboard state
   logic            out_valid_q, out_valid_d;
   logic [BITS-1:0] out_op_a_q, out_op_a_d;
   logic [BITS-1:0] out_op_b_q, out_op_b_d;
   logic [ADDR-1:0] out_rd_q, out_rd_d;
   logic            out_wen_q, out_wen_d;
   logic [NREG-1:0] pend_q, pend_d;

   // resolve / hazard intermediates
   logic            wb_hit_rs1, wb_hit_rs2, wb_hit_rd;
   logic            blk_rs1, blk_rs2, blk_rd;
   logic            hazard, accept;
   logic [BITS-1:0] op_a, op_b;

   // Register file ports are straight wires; x0 writes are suppressed and no
   // write is issued while held in reset.
   always_comb begin
      bus.rf_address_a     = bus.in_rs1;
      bus.rf_address_b     = bus.in_rs2;
      bus.rf_address_write = bus.wb_rd;
      bus.rf_data_write    = bus.wb_data;
      bus.rf_write_enable  = bus.wb_valid && (bus.wb_rd != '0) && rst_n;
   end

   // Operand resolve and hazard detection. The register file returns pre-edge
   // contents, so a writeback in the same cycle must be bypassed and also
   // releases any stall on that register.
   always_comb begin
      wb_hit_rs1 = bus.wb_valid && (bus.wb_rd == bus.in_rs1);
      wb_hit_rs2 = bus.wb_valid && (bus.wb_rd == bus.in_rs2);
      wb_hit_rd  = bus.wb_valid && (bus.wb_rd == bus.in_rd);

      if (bus.in_rs1 == '0)  op_a = '0;
      else if (wb_hit_rs1)   op_a = bus.wb_data;
      else                   op_a = bus.rf_data_a;

      if (bus.in_rs2 == '0)  op_b = '0;
      else if (wb_hit_rs2)   op_b = bus.wb_data;
      else                   op_b = bus.rf_data_b;

      blk_rs1 = pend_q[bus.in_rs1] && (bus.in_rs1 != '0) && !wb_hit_rs1;
      blk_rs2 = pend_q[bus.in_rs2] && (bus.in_rs2 != '0) && !wb_hit_rs2;
      blk_rd  = bus.in_wen && (bus.in_rd != '0) && pend_q[bus.in_rd] && !wb_hit_rd;

      hazard       = bus.in_valid && (blk_rs1 || blk_rs2 || blk_rd);
      bus.in_ready = (!out_valid_q || bus.out_ready) && !hazard;
      accept       = bus.in_valid && bus.in_ready;
   end

   // Next-state for the output register and scoreboard. A writeback clears
   // its pending bit; a newly accepted writer sets its bit, and the set wins
   // when both name the same register.
   always_comb begin
      out_valid_d = out_valid_q;
      out_op_a_d  = out_op_a_q;
      out_op_b_d  = out_op_b_q;
      out_rd_d    = out_rd_q;
      out_wen_d   = out_wen_q;
      pend_d      = pend_q;

      if (accept) begin
         out_valid_d = 1'b1;
         out_op_a_d  = op_a;
         out_op_b_d  = op_b;
         out_rd_d    = bus.in_rd;
         out_wen_d   = bus.in_wen;
      end else if (out_valid_q && bus.out_ready) begin
         out_valid_d = 1'b0;
      end

      if (bus.wb_valid) begin
         pend_d[bus.wb_rd] = 1'b0;
      end
      if (accept && bus.in_wen && (bus.in_rd != '0)) begin
         pend_d[bus.in_rd] = 1'b1;
      end
      pend_d[0] = 1'b0;
   end

   // State registers; reset drops any held bundle and all pending marks.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_op_a_q  <= '0;
         out_op_b_q  <= '0;
         out_rd_q    <= '0;
         out_wen_q   <= 1'b0;
         pend_q      <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         out_op_a_q  <= out_op_a_d;
         out_op_b_q  <= out_op_b_d;
         out_rd_q    <= out_rd_d;
         out_wen_q   <= out_wen_d;
         pend_q      <= pend_d;
      end
   end

   // Registered bundle to execute
   always_comb begin
      bus.out_valid = out_valid_q;
      bus.out_op_a  = out_op_a_q;
      bus.out_op_b  = out_op_b_q;
      bus.out_rd    = out_rd_q;
      bus.out_wen   = out_wen_q;
   end
endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: directed scenarios followed by a random phase, all
// checked against an architectural model (register values, pending writers,
// and the expected output bundle) held in the bench.
module tb_operand_fetch;
   localparam int BITS = 32;
   localparam int ADDR = 5;
   localparam int NREG = 32;

   logic clk;
   logic rst_n;
   logic rf_clear;

   operand_fetch_if #(.BITS(BITS), .ADDR(ADDR)) bus ();

   operand_fetch #(.BITS(BITS), .ADDR(ADDR)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.master)
   );

   // clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // register file environment: combinational reads, write at the rising edge
   logic [BITS-1:0] rf_mem [NREG];
   assign bus.rf_data_a = rf_mem[bus.rf_address_a];
   assign bus.rf_data_b = rf_mem[bus.rf_address_b];
   always @(posedge clk) begin
      if (rf_clear) begin
         for (int i = 0; i < NREG; i++) rf_mem[i] <= '0;
      end else if (bus.rf_write_enable) begin
         rf_mem[bus.rf_address_write] <= bus.rf_data_write;
      end
   end

   // counters
   int tests;
   int fails;

   // reference model state
   logic [BITS-1:0] ref_regs [NREG];
   bit              ref_pend [NREG];
   logic            ref_valid;
   logic [BITS-1:0] ref_a, ref_b;
   logic [ADDR-1:0] ref_rd;
   logic            ref_wen;
   logic            exp_ready;
   logic            exp_we;
   logic            last_accept;

   task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < NREG; i++) ref_pend[i] = 1'b0;
      ref_valid   = 1'b0;
      ref_a       = '0;
      ref_b       = '0;
      ref_rd      = '0;
      ref_wen     = 1'b0;
      last_accept = 1'b0;
   endtask

   // a register is still awaited if someone will write it later, not now
   function automatic bit awaited(logic [ADDR-1:0] r);
      return (r != 0) && ref_pend[r] && !(bus.wb_valid && bus.wb_rd == r);
   endfunction

   // architectural value of r once this cycle's writeback has landed
   function automatic logic [BITS-1:0] arch_value(logic [ADDR-1:0] r);
      return (r == 0) ? '0 : ref_regs[r];
   endfunction

   task automatic model_comb();
      bit stall;
      stall = bus.in_valid && (awaited(bus.in_rs1) || awaited(bus.in_rs2) ||
                               (bus.in_wen && awaited(bus.in_rd)));
      exp_ready = (!ref_valid || bus.out_ready) && !stall;
      exp_we    = rst_n && bus.wb_valid && (bus.wb_rd != 0);
   endtask

   task automatic model_edge();
      bit acc;
      acc = rst_n && bus.in_valid && exp_ready;
      last_accept = acc;
      if (!rst_n) return;
      if (bus.wb_valid && bus.wb_rd != 0) ref_regs[bus.wb_rd] = bus.wb_data;
      if (bus.wb_valid) ref_pend[bus.wb_rd] = 1'b0;
      if (acc) begin
         ref_valid = 1'b1;
         ref_a     = arch_value(bus.in_rs1);
         ref_b     = arch_value(bus.in_rs2);
         ref_rd    = bus.in_rd;
         ref_wen   = bus.in_wen;
         if (bus.in_wen && bus.in_rd != 0) ref_pend[bus.in_rd] = 1'b1;
      end else if (bus.out_ready) begin
         ref_valid = 1'b0;
      end
   endtask

   task automatic check_outputs(string tag);
      check({tag, ".out_valid"}, 32'(bus.out_valid), 32'(ref_valid));
      check({tag, ".op_a"}, bus.out_op_a, ref_a);
      check({tag, ".op_b"}, bus.out_op_b, ref_b);
      check({tag, ".rd"}, 32'(bus.out_rd), 32'(ref_rd));
      check({tag, ".wen"}, 32'(bus.out_wen), 32'(ref_wen));
   endtask

   // One clock: inputs already driven at the falling edge.
   task automatic cycle();
      #1;
      model_comb();
      check("in_ready", 32'(bus.in_ready), 32'(exp_ready));
      check("rf_we", 32'(bus.rf_write_enable), 32'(exp_we));
      @(posedge clk);
      model_edge();
      #1;
      check_outputs("post_edge");
      @(negedge clk);
   endtask

   task automatic set_in(bit v, int rs1, int rs2, int rd, bit wen);
      bus.in_valid = v;
      bus.in_rs1   = 5'(rs1);
      bus.in_rs2   = 5'(rs2);
      bus.in_rd    = 5'(rd);
      bus.in_wen   = wen;
   endtask

   task automatic set_wb(bit v, int rd, logic [BITS-1:0] d);
      bus.wb_valid = v;
      bus.wb_rd    = 5'(rd);
      bus.wb_data  = d;
   endtask

   initial begin
      int pq[$];
      tests = 0;
      fails = 0;
      rst_n = 1'b0;
      rf_clear = 1'b1;
      for (int i = 0; i < NREG; i++) ref_regs[i] = '0;
      model_reset();
      set_in(0, 0, 0, 0, 0);
      set_wb(0, 0, '0);
      bus.out_ready = 1'b1;
      repeat (2) @(negedge clk);
      rf_clear = 1'b0;

      // reset state: no writes issued even with a writeback present
      set_wb(1, 5, 32'hdeadbeef);
      #1;
      check("rst_we", 32'(bus.rf_write_enable), 32'd0);
      check("rst_valid", 32'(bus.out_valid), 32'd0);
      check("rst_op_a", bus.out_op_a, 32'd0);
      cycle();
      set_wb(0, 0, '0);
      rst_n = 1'b1;

      // x0 operands
      set_in(1, 0, 0, 0, 0);
      cycle();
      check("idle_valid", 32'(bus.out_valid), 32'd1);
      check("idle_a", bus.out_op_a, 32'd0);
      check("idle_b", bus.out_op_b, 32'd0);

      // write then read
      set_in(0, 0, 0, 0, 0);
      set_wb(1, 1, 32'haabbccdd);
      cycle();
      set_wb(0, 0, '0);
      set_in(1, 1, 2, 0, 0);
      cycle();
      check("wr_rd_a", bus.out_op_a, 32'haabbccdd);
      check("wr_rd_b", bus.out_op_b, 32'd0);

      // same-cycle bypass, then the written value from the register file
      set_in(1, 0, 2, 0, 0);
      set_wb(1, 2, 32'hffffffff);
      cycle();
      check("bypass_b", bus.out_op_b, 32'hffffffff);
      set_wb(0, 0, '0);
      set_in(1, 2, 0, 0, 0);
      cycle();
      check("rf_after_byp", bus.out_op_a, 32'hffffffff);

      // x0 write suppressed
      set_in(0, 0, 0, 0, 0);
      set_wb(1, 0, 32'h12345678);
      #1;
      check("x0_we", 32'(bus.rf_write_enable), 32'd0);
      cycle();
      set_wb(0, 0, '0);
      set_in(1, 0, 0, 0, 0);
      cycle();
      check("x0_read", bus.out_op_a, 32'd0);

      // RAW stall released by writeback in the same cycle
      set_in(1, 0, 0, 3, 1);
      cycle();
      set_in(1, 3, 0, 0, 0);
      #1;
      check("raw_stall", 32'(bus.in_ready), 32'd0);
      cycle();
      cycle();
      set_wb(1, 3, 32'ha0a0a0a0);
      #1;
      check("raw_release", 32'(bus.in_ready), 32'd1);
      cycle();
      check("raw_a", bus.out_op_a, 32'ha0a0a0a0);
      set_wb(0, 0, '0);
      set_in(1, 3, 0, 0, 0);
      #1;
      check("raw_cleared", 32'(bus.in_ready), 32'd1);
      cycle();

      // backpressure and WAW
      set_in(1, 0, 0, 3, 1);
      cycle();
      bus.out_ready = 1'b0;
      set_in(1, 0, 0, 3, 1);
      for (int i = 0; i < 3; i++) begin
         #1;
         check("bp_ready", 32'(bus.in_ready), 32'd0);
         cycle();
         check("bp_rd", 32'(bus.out_rd), 32'd3);
         check("bp_valid", 32'(bus.out_valid), 32'd1);
      end
      bus.out_ready = 1'b1;
      #1;
      check("waw_stall", 32'(bus.in_ready), 32'd0);
      cycle();
      set_wb(1, 3, 32'h00000005);
      #1;
      check("waw_release", 32'(bus.in_ready), 32'd1);
      cycle();
      set_wb(0, 0, '0);
      set_in(1, 3, 0, 0, 0);
      #1;
      check("waw_pend_kept", 32'(bus.in_ready), 32'd0);
      cycle();
      set_wb(1, 3, 32'h00000077);
      cycle();
      check("waw_a", bus.out_op_a, 32'h00000077);
      set_wb(0, 0, '0);

      // reset in the middle of operation
      set_in(1, 0, 0, 4, 1);
      cycle();
      set_in(0, 0, 0, 0, 0);
      bus.out_ready = 1'b0;
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
      check("mid_rst_rd", 32'(bus.out_rd), 32'd0);
      check("mid_rst_wen", 32'(bus.out_wen), 32'd0);
      @(negedge clk);
      cycle();
      rst_n = 1'b1;
      bus.out_ready = 1'b1;
      set_in(1, 4, 0, 0, 0);
      #1;
      check("post_rst_ready", 32'(bus.in_ready), 32'd1);
      cycle();

      // random traffic on a small register window to provoke hazards
      last_accept = 1'b1;
      for (int n = 0; n < 400; n++) begin
         if (last_accept || $urandom_range(0, 3) == 0) begin
            set_in($urandom_range(0, 4) != 0, $urandom_range(0, 7), $urandom_range(0, 7),
                   $urandom_range(0, 7), $urandom_range(0, 1) == 1);
         end
         pq.delete();
         for (int r = 0; r < NREG; r++) if (ref_pend[r]) pq.push_back(r);
         if ($urandom_range(0, 9) < 4) begin
            if (pq.size() > 0 && $urandom_range(0, 9) < 7)
               set_wb(1, pq[$urandom_range(0, pq.size() - 1)], $urandom);
            else
               set_wb(1, $urandom_range(0, 7), $urandom);
         end else begin
            set_wb(0, 0, '0);
         end
         bus.out_ready = ($urandom_range(0, 3) != 0);
         cycle();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
